// File: rtl/pe_sys_pkg.sv
// Shared definitions for the PE memory arbiter: FSM state encoding and
// default sizing of the PE array.
package pe_sys_pkg;

   localparam int NUM_PE_DEF    = 4;
   localparam int BURST_LEN_DEF = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      ARB   = 3'd2,
      LOAD  = 3'd3,
      STORE = 3'd4,
      FIN   = 3'd5
   } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted requester at or after ptr,
// wrapping at NUM_PE.
module rr_picker #(
   parameter int NUM_PE = 4,
   parameter int IDX_W  = 2
) (
   input  logic [NUM_PE-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic              any,
   output logic [IDX_W-1:0]  idx
);

   int               pos;
   logic [IDX_W-1:0] pos_idx;

   always_comb begin
      any     = 1'b0;
      idx     = '0;
      pos     = 0;
      pos_idx = '0;
      // Scan farthest-first so the requester nearest to ptr is the last writer.
      for (int i = NUM_PE - 1; i >= 0; i--) begin
         pos = int'(ptr) + i;
         if (pos >= NUM_PE) pos = pos - NUM_PE;
         pos_idx = IDX_W'(pos);
         if (req[pos_idx]) begin
            any = 1'b1;
            idx = pos_idx;
         end
      end
   end

endmodule

// File: rtl/pe_mem_arbiter.sv
// Shares one input-memory read port and one output-memory write port among
// NUM_PE controllers: store-first round robin, burst-locked loads, start/done.
module pe_mem_arbiter
   import pe_sys_pkg::*;
#(
   parameter int NUM_PE    = NUM_PE_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int IDX_W     = $clog2(NUM_PE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic [NUM_PE-1:0] pe_load_req,
   input  logic [NUM_PE-1:0] pe_store_req,
   input  logic [NUM_PE-1:0] pe_done,
   output logic              start_out,
   output logic [NUM_PE-1:0] pe_grant,
   output logic [NUM_PE-1:0] pe_hold,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [IDX_W-1:0]  mem_sel,
   output logic              all_done
);

   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]  burst_cnt, burst_cnt_nxt;
   logic [NUM_PE-1:0] grant_nxt;
   logic [IDX_W-1:0]  sel_nxt;
   logic              st_any, ld_any;
   logic [IDX_W-1:0]  st_idx, ld_idx;

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
      next_ptr = (cur == IDX_W'(NUM_PE - 1)) ? '0 : cur + 1'b1;
   endfunction

   rr_picker #(.NUM_PE(NUM_PE), .IDX_W(IDX_W)) u_store_pick (
      .req (pe_store_req),
      .ptr (rr_ptr),
      .any (st_any),
      .idx (st_idx)
   );

   rr_picker #(.NUM_PE(NUM_PE), .IDX_W(IDX_W)) u_load_pick (
      .req (pe_load_req),
      .ptr (rr_ptr),
      .any (ld_any),
      .idx (ld_idx)
   );

   assign pe_hold = (pe_load_req | pe_store_req) & ~pe_grant;

   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      burst_cnt_nxt = burst_cnt;
      grant_nxt     = pe_grant;
      sel_nxt       = mem_sel;
      case (state)
         IDLE:  if (start_in) state_nxt = START;
         START: state_nxt = ARB;
         ARB: begin
            grant_nxt = '0;
            if (st_any) begin
               state_nxt         = STORE;
               sel_nxt           = st_idx;
               grant_nxt[st_idx] = 1'b1;
            end else if (ld_any) begin
               state_nxt         = LOAD;
               sel_nxt           = ld_idx;
               burst_cnt_nxt     = '0;
               grant_nxt[ld_idx] = 1'b1;
            end else if (&pe_done) begin
               state_nxt = FIN;
            end
         end
         LOAD: begin
            if (!$onehot(pe_grant)) begin
               state_nxt = IDLE;
            end else if (burst_cnt == CNT_W'(BURST_LEN - 1)) begin
               state_nxt     = ARB;
               rr_ptr_nxt    = next_ptr(mem_sel);
               burst_cnt_nxt = '0;
               grant_nxt     = '0;
            end else begin
               burst_cnt_nxt = burst_cnt + 1'b1;
            end
         end
         STORE: begin
            if (!$onehot(pe_grant)) begin
               state_nxt = IDLE;
            end else begin
               state_nxt  = ARB;
               rr_ptr_nxt = next_ptr(mem_sel);
               grant_nxt  = '0;
            end
         end
         FIN: state_nxt = FIN;
         default: state_nxt = IDLE;
      endcase
      // Recovery from a corrupted state/grant register drops everything.
      if (state_nxt == IDLE) begin
         grant_nxt     = '0;
         burst_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         pe_grant  <= '0;
         mem_sel   <= '0;
         mem_rd_en <= 1'b0;
         mem_wr_en <= 1'b0;
         start_out <= 1'b0;
         all_done  <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         burst_cnt <= burst_cnt_nxt;
         pe_grant  <= grant_nxt;
         mem_sel   <= sel_nxt;
         mem_rd_en <= (state_nxt == LOAD);
         mem_wr_en <= (state_nxt == STORE);
         start_out <= (state_nxt == START);
         all_done  <= (state_nxt == FIN);
      end
   end

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Scoreboard bench for pe_mem_arbiter: expected grant events are queued as
// requests are raised and matched against grant events seen on the outputs.
module tb_pe_mem_arbiter;

   localparam int BURST = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_in;
   logic [3:0] pe_load_req, pe_store_req, pe_done;
   logic       start_out, mem_rd_en, mem_wr_en, all_done;
   logic [3:0] pe_grant, pe_hold;
   logic [1:0] mem_sel;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int idx;
      int rd;
      int wr;
      bit gap_ok;
      bit sel_ok;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   ev_t cur;
   bit         active = 1'b0;
   logic [3:0] prev_grant = '0;
   int         idle_run = 1;
   int         stray = 0;

   pe_mem_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .start_in     (start_in),
      .pe_load_req  (pe_load_req),
      .pe_store_req (pe_store_req),
      .pe_done      (pe_done),
      .start_out    (start_out),
      .pe_grant     (pe_grant),
      .pe_hold      (pe_hold),
      .mem_rd_en    (mem_rd_en),
      .mem_wr_en    (mem_wr_en),
      .mem_sel      (mem_sel),
      .all_done     (all_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_ev(input int idx, input bit store);
      ev_t e;
      e.idx    = idx;
      e.rd     = store ? 0 : BURST;
      e.wr     = store ? 1 : 0;
      e.gap_ok = 1'b1;
      e.sel_ok = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(input logic [3:0] mask, input int budget);
      int n = 0;
      do begin
         tick();
         n++;
      end while (pe_grant != mask && n < budget);
      if (pe_grant != mask) chk("grant_wait", int'(pe_grant), int'(mask));
   endtask

   task automatic drain(input int budget);
      int  n = 0;
      ev_t o, e;
      while (obs_q.size() < exp_q.size() && n < budget) begin
         tick();
         n++;
      end
      chk("sb_count", obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk("ev_idx", o.idx, e.idx);
         chk("ev_rd_beats", o.rd, e.rd);
         chk("ev_wr_beats", o.wr, e.wr);
         chk("ev_dead_cycle", int'(o.gap_ok), int'(e.gap_ok));
         chk("ev_sel_match", int'(o.sel_ok), int'(e.sel_ok));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   // Grant-event monitor: a grant event ends when pe_grant changes.
   always @(negedge clk) begin
      if (rst) begin
         active     = 1'b0;
         prev_grant = '0;
         idle_run   = 1;
      end else begin
         if (active && pe_grant != prev_grant) begin
            obs_q.push_back(cur);
            active = 1'b0;
         end
         if (pe_grant != '0 && !active) begin
            cur.idx    = int'(mem_sel);
            cur.rd     = 0;
            cur.wr     = 0;
            cur.gap_ok = (idle_run > 0);
            cur.sel_ok = 1'b1;
            active     = 1'b1;
         end
         if (active) begin
            cur.rd = cur.rd + int'(mem_rd_en);
            cur.wr = cur.wr + int'(mem_wr_en);
            if (pe_grant != (4'b0001 << mem_sel)) cur.sel_ok = 1'b0;
         end else if (mem_rd_en || mem_wr_en) begin
            stray++;
         end
         idle_run   = (pe_grant == '0) ? idle_run + 1 : 0;
         prev_grant = pe_grant;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start_in = 1'b0;
      pe_load_req = 4'b0101; pe_store_req = 4'b0000; pe_done = 4'b0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", int'(pe_grant), 0);
      chk("rst_start", int'(start_out), 0);
      chk("rst_rd", int'(mem_rd_en), 0);
      chk("rst_wr", int'(mem_wr_en), 0);
      chk("rst_sel", int'(mem_sel), 0);
      chk("rst_done", int'(all_done), 0);
      chk("rst_hold", int'(pe_hold), 'b0101);
      pe_load_req = 4'b0000;
      tick();
      rst = 1'b0;

      // start pulse, start_in held into ARB to show it is ignored there
      tick();
      start_in = 1'b1;
      @(negedge clk);
      chk("idle_start_out", int'(start_out), 0);
      tick();
      @(negedge clk);
      chk("start_pulse", int'(start_out), 1);
      chk("start_grant", int'(pe_grant), 0);
      tick();
      @(negedge clk);
      chk("start_one_cycle", int'(start_out), 0);
      start_in = 1'b0;

      // PE0 and PE2 loads with rr_ptr=0
      exp_ev(0, 1'b0); exp_ev(2, 1'b0);
      pe_load_req = 4'b0101;
      wait_grant(4'b0001, 10);
      pe_load_req = 4'b0100;
      @(negedge clk);
      chk("hold_pe2", int'(pe_hold), 'b0100);
      wait_grant(4'b0100, 10);
      pe_load_req = 4'b0000;
      drain(20);

      // store from PE3 during PE1 burst beats pending PE2 load
      exp_ev(1, 1'b0);
      pe_load_req = 4'b0110;
      wait_grant(4'b0010, 10);
      pe_store_req = 4'b1000;
      pe_load_req  = 4'b0100;
      exp_ev(3, 1'b1); exp_ev(2, 1'b0);
      @(negedge clk);
      chk("hold_store_pend", int'(pe_hold), 'b1100);
      wait_grant(4'b1000, 10);
      pe_store_req = 4'b0000;
      wait_grant(4'b0100, 10);
      pe_load_req = 4'b0000;
      drain(20);

      // rr_ptr=3: PE3 first, then wrap to PE0
      exp_ev(3, 1'b0); exp_ev(0, 1'b0);
      pe_load_req = 4'b1001;
      wait_grant(4'b1000, 10);
      pe_load_req = 4'b0001;
      wait_grant(4'b0001, 10);
      pe_load_req = 4'b0000;
      drain(20);

      // reset in the third beat of a load burst
      pe_load_req = 4'b0010;
      wait_grant(4'b0010, 10);
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_grant", int'(pe_grant), 0);
      chk("midrst_rd", int'(mem_rd_en), 0);
      chk("midrst_wr", int'(mem_wr_en), 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("postrst_idle_grant", int'(pe_grant), 0);
      chk("postrst_idle_rd", int'(mem_rd_en), 0);
      exp_ev(0, 1'b0); exp_ev(1, 1'b0);
      pe_load_req = 4'b0011;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      wait_grant(4'b0001, 10);
      pe_load_req = 4'b0010;
      wait_grant(4'b0010, 10);
      pe_load_req = 4'b0000;
      drain(20);

      // done aggregation
      pe_done = 4'b0111;
      repeat (3) tick();
      @(negedge clk);
      chk("partial_done", int'(all_done), 0);
      tick();
      pe_done = 4'b1111;
      @(negedge clk);
      chk("done_latency", int'(all_done), 0);
      tick();
      @(negedge clk);
      chk("all_done_set", int'(all_done), 1);
      start_in = 1'b1;
      pe_load_req = 4'b0001;
      repeat (4) tick();
      @(negedge clk);
      chk("all_done_sticky", int'(all_done), 1);
      chk("fin_no_start", int'(start_out), 0);
      chk("fin_no_grant", int'(pe_grant), 0);
      start_in = 1'b0;
      pe_load_req = 4'b0000;

      chk("extra_events", obs_q.size(), 0);
      chk("stray_strobes", stray, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
